// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered RV32I/RV32M decode stage with a
// valid/ready handshake, 2-entry skid buffer and synchronous flush.
module decode_stage_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int ENABLE_M   = 1,
   parameter int ALU_OP_W   = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic [4:0]            rs1_addr_o,
   output logic [4:0]            rs2_addr_o,
   output logic [4:0]            rd_addr_o,
   output logic [DATA_WIDTH-1:0] imm_o,
   output logic [ALU_OP_W-1:0]   alu_op_o,
   output logic                  reg_write_en_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic                  mem_unsigned_o,
   output logic                  branch_o,
   output logic                  jump_o,
   output logic                  jalr_o,
   output logic                  uses_rs1_o,
   output logic                  uses_rs2_o,
   output logic                  is_muldiv_o,
   output logic [1:0]            mem_size_o,
   output logic [1:0]            result_src_o,
   output logic                  illegal_o
);

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LD    = 7'b0000011;
   localparam logic [6:0] OPC_ST    = 7'b0100011;
   localparam logic [6:0] OPC_OPI   = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
      logic [DATA_WIDTH-1:0] imm;
      logic [ALU_OP_W-1:0]   alu_op;
      logic                  reg_write_en;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_unsigned;
      logic                  branch;
      logic                  jump;
      logic                  jalr;
      logic                  uses_rs1;
      logic                  uses_rs2;
      logic                  is_muldiv;
      logic [1:0]            mem_size;
      logic [1:0]            result_src;
      logic                  illegal;
   } bundle_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   bundle_t     r_main;
   bundle_t     r_skid;
   bundle_t     w_dec;
   logic        w_acc;
   logic        w_fire;
   logic        w_ld_main;
   logic        w_ld_skid;
   logic        w_main_from_skid;

   logic [31:0] w_ins;
   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_imm_sh;
   logic [31:0] w_imm32;
   logic [4:0]  w_op;
   logic        w_ill;
   logic        w_wr;

   logic        w_is_lui;
   logic        w_is_auipc;
   logic        w_is_jal;
   logic        w_is_jalr;
   logic        w_is_br;
   logic        w_is_ld;
   logic        w_is_st;
   logic        w_is_opi;
   logic        w_is_op;

   // base integer op selected by funct3; alt picks SUB/SRA
   function automatic logic [4:0] f_alu_base(
      input logic [2:0] f3,
      input logic       alt
   );
      logic [4:0] v;
      case (f3)
         3'b000:  v = alt ? 5'd1 : 5'd0;
         3'b001:  v = 5'd2;
         3'b010:  v = 5'd3;
         3'b011:  v = 5'd4;
         3'b100:  v = 5'd5;
         3'b101:  v = alt ? 5'd7 : 5'd6;
         3'b110:  v = 5'd8;
         default: v = 5'd9;
      endcase
      return v;
   endfunction

   assign w_ins = instr_i[31:0];
   assign w_opc = w_ins[6:0];
   assign w_f3  = w_ins[14:12];
   assign w_f7  = w_ins[31:25];

   assign w_imm_i  = {{20{w_ins[31]}}, w_ins[31:20]};
   assign w_imm_s  = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
   assign w_imm_b  = {{20{w_ins[31]}}, w_ins[7],
                      w_ins[30:25], w_ins[11:8], 1'b0};
   assign w_imm_u  = {w_ins[31:12], 12'b0};
   assign w_imm_j  = {{12{w_ins[31]}}, w_ins[19:12],
                      w_ins[20], w_ins[30:21], 1'b0};
   assign w_imm_sh = {27'b0, w_ins[24:20]};

   assign w_is_lui   = (w_opc == OPC_LUI);
   assign w_is_auipc = (w_opc == OPC_AUIPC);
   assign w_is_jal   = (w_opc == OPC_JAL);
   assign w_is_jalr  = (w_opc == OPC_JALR);
   assign w_is_br    = (w_opc == OPC_BR);
   assign w_is_ld    = (w_opc == OPC_LD);
   assign w_is_st    = (w_opc == OPC_ST);
   assign w_is_opi   = (w_opc == OPC_OPI);
   assign w_is_op    = (w_opc == OPC_OP);

   // combinational decode of the offered instruction
   always_comb begin
      w_dec     = '0;
      w_imm32   = '0;
      w_op      = 5'd0;
      w_ill     = 1'b0;
      w_wr      = 1'b0;
      w_dec.pc  = pc_i;
      w_dec.rs1 = w_ins[19:15];
      w_dec.rs2 = w_ins[24:20];
      w_dec.rd  = w_ins[11:7];
      unique case (1'b1)
         w_is_lui: begin
            w_wr             = 1'b1;
            w_imm32          = w_imm_u;
            w_dec.result_src = 2'b11;
         end
         w_is_auipc: begin
            w_wr    = 1'b1;
            w_imm32 = w_imm_u;
         end
         w_is_jal: begin
            w_wr             = 1'b1;
            w_dec.jump       = 1'b1;
            w_dec.result_src = 2'b10;
            w_imm32          = w_imm_j;
         end
         w_is_jalr: begin
            w_wr             = 1'b1;
            w_dec.jump       = 1'b1;
            w_dec.jalr       = 1'b1;
            w_dec.uses_rs1   = 1'b1;
            w_dec.result_src = 2'b10;
            w_imm32          = w_imm_i;
            w_ill            = (w_f3 != 3'b000);
         end
         w_is_br: begin
            w_dec.branch   = 1'b1;
            w_dec.uses_rs1 = 1'b1;
            w_dec.uses_rs2 = 1'b1;
            w_imm32        = w_imm_b;
            case (w_f3)
               3'b000:  w_op = 5'd10;
               3'b001:  w_op = 5'd11;
               3'b100:  w_op = 5'd12;
               3'b101:  w_op = 5'd13;
               3'b110:  w_op = 5'd14;
               3'b111:  w_op = 5'd15;
               default: w_ill = 1'b1;
            endcase
         end
         w_is_ld: begin
            w_wr               = 1'b1;
            w_dec.mem_read     = 1'b1;
            w_dec.uses_rs1     = 1'b1;
            w_dec.result_src   = 2'b01;
            w_dec.mem_size     = w_f3[1:0];
            w_dec.mem_unsigned = w_f3[2];
            w_imm32            = w_imm_i;
            w_ill              = (w_f3 == 3'b011) |
                                 (w_f3[2:1] == 2'b11);
         end
         w_is_st: begin
            w_dec.mem_write = 1'b1;
            w_dec.uses_rs1  = 1'b1;
            w_dec.uses_rs2  = 1'b1;
            w_dec.mem_size  = w_f3[1:0];
            w_imm32         = w_imm_s;
            w_ill           = (w_f3 >= 3'b011);
         end
         w_is_opi: begin
            w_wr           = 1'b1;
            w_dec.uses_rs1 = 1'b1;
            w_imm32        = w_imm_i;
            w_op           = f_alu_base(w_f3, 1'b0);
            if (w_f3 == 3'b001) begin
               w_imm32 = w_imm_sh;
               w_ill   = (w_f7 != F7_BASE);
            end else if (w_f3 == 3'b101) begin
               w_imm32 = w_imm_sh;
               w_op    = f_alu_base(w_f3, w_f7 == F7_ALT);
               w_ill   = (w_f7 != F7_BASE) &&
                         (w_f7 != F7_ALT);
            end
         end
         w_is_op: begin
            w_wr           = 1'b1;
            w_dec.uses_rs1 = 1'b1;
            w_dec.uses_rs2 = 1'b1;
            if (w_f7 == F7_MUL) begin
               if (ENABLE_M != 0) begin
                  w_op            = {2'b10, w_f3};
                  w_dec.is_muldiv = 1'b1;
               end else begin
                  w_ill = 1'b1;
               end
            end else if (w_f7 == F7_BASE) begin
               w_op = f_alu_base(w_f3, 1'b0);
            end else if (w_f7 == F7_ALT &&
                         (w_f3 == 3'b000 ||
                          w_f3 == 3'b101)) begin
               w_op = f_alu_base(w_f3, 1'b1);
            end else begin
               w_ill = 1'b1;
            end
         end
         default: w_ill = 1'b1;
      endcase
      w_dec.alu_op       = ALU_OP_W'(w_op);
      w_dec.imm          = {{(DATA_WIDTH-31){w_imm32[31]}},
                            w_imm32[30:0]};
      w_dec.illegal      = w_ill;
      w_dec.reg_write_en = w_wr & ~w_ill &
                           (w_dec.rd != 5'd0);
      if (w_ill) begin
         w_dec.mem_read  = 1'b0;
         w_dec.mem_write = 1'b0;
         w_dec.branch    = 1'b0;
         w_dec.jump      = 1'b0;
         w_dec.jalr      = 1'b0;
      end
   end

   assign in_ready_o  = (r_state != S_TWO);
   assign out_valid_o = (r_state != S_EMPTY);
   assign w_acc       = in_valid_i & in_ready_o;
   assign w_fire      = out_valid_o & out_ready_i;

   // buffer occupancy register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next occupancy and entry load controls; flush wins
   always_comb begin
      w_state_nxt      = r_state;
      w_ld_main        = 1'b0;
      w_ld_skid        = 1'b0;
      w_main_from_skid = 1'b0;
      if (flush_i) begin
         w_state_nxt = S_EMPTY;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_acc) begin
                  w_state_nxt = S_ONE;
                  w_ld_main   = 1'b1;
               end
            end
            S_ONE: begin
               if (w_acc && w_fire) begin
                  w_ld_main = 1'b1;
               end else if (w_acc) begin
                  w_state_nxt = S_TWO;
                  w_ld_skid   = 1'b1;
               end else if (w_fire) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_fire) begin
                  w_state_nxt      = S_ONE;
                  w_ld_main        = 1'b1;
                  w_main_from_skid = 1'b1;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // main and skid payload registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_ld_main) begin
            r_main <= w_main_from_skid ? r_skid : w_dec;
         end
         if (w_ld_skid) begin
            r_skid <= w_dec;
         end
      end
   end

   assign pc_o           = r_main.pc;
   assign rs1_addr_o     = r_main.rs1;
   assign rs2_addr_o     = r_main.rs2;
   assign rd_addr_o      = r_main.rd;
   assign imm_o          = r_main.imm;
   assign alu_op_o       = r_main.alu_op;
   assign reg_write_en_o = r_main.reg_write_en;
   assign mem_read_o     = r_main.mem_read;
   assign mem_write_o    = r_main.mem_write;
   assign mem_unsigned_o = r_main.mem_unsigned;
   assign branch_o       = r_main.branch;
   assign jump_o         = r_main.jump;
   assign jalr_o         = r_main.jalr;
   assign uses_rs1_o     = r_main.uses_rs1;
   assign uses_rs2_o     = r_main.uses_rs2;
   assign is_muldiv_o    = r_main.is_muldiv;
   assign mem_size_o     = r_main.mem_size;
   assign result_src_o   = r_main.result_src;
   assign illegal_o      = r_main.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed and randomized checks of the
// decode stage against a behavioural decode and queue model.
module tb_decode_stage_pipe;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [4:0]  op;
      logic        rwe;
      logic        mrd;
      logic        mwr;
      logic        mus;
      logic        br;
      logic        jmp;
      logic        jalr;
      logic        u1;
      logic        u2;
      logic        md;
      logic [1:0]  msz;
      logic [1:0]  rsrc;
      logic        ill;
   } b_t;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
   } tx_t;

   localparam int ALU_T [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [31:0] pc;

   logic        in_ready, out_valid;
   logic [31:0] d_pc, d_imm;
   logic [4:0]  d_rs1, d_rs2, d_rd, d_op;
   logic        d_rwe, d_mrd, d_mwr, d_mus, d_br, d_jmp;
   logic        d_jalr, d_u1, d_u2, d_md, d_ill;
   logic [1:0]  d_msz, d_rsrc;

   logic        n_in_ready, n_out_valid;
   logic [31:0] n_pc, n_imm;
   logic [4:0]  n_rs1, n_rs2, n_rd, n_op;
   logic        n_rwe, n_mrd, n_mwr, n_mus, n_br, n_jmp;
   logic        n_jalr, n_u1, n_u2, n_md, n_ill;
   logic [1:0]  n_msz, n_rsrc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_stage_pipe #(.DATA_WIDTH(32), .ENABLE_M(1), .ALU_OP_W(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instr_i(instr), .pc_i(pc),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .pc_o(d_pc), .rs1_addr_o(d_rs1), .rs2_addr_o(d_rs2),
      .rd_addr_o(d_rd), .imm_o(d_imm), .alu_op_o(d_op),
      .reg_write_en_o(d_rwe), .mem_read_o(d_mrd),
      .mem_write_o(d_mwr), .mem_unsigned_o(d_mus),
      .branch_o(d_br), .jump_o(d_jmp), .jalr_o(d_jalr),
      .uses_rs1_o(d_u1), .uses_rs2_o(d_u2),
      .is_muldiv_o(d_md), .mem_size_o(d_msz),
      .result_src_o(d_rsrc), .illegal_o(d_ill)
   );

   decode_stage_pipe #(.DATA_WIDTH(32), .ENABLE_M(0), .ALU_OP_W(5)) u_nom (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(n_in_ready),
      .instr_i(instr), .pc_i(pc),
      .out_valid_o(n_out_valid), .out_ready_i(out_ready),
      .pc_o(n_pc), .rs1_addr_o(n_rs1), .rs2_addr_o(n_rs2),
      .rd_addr_o(n_rd), .imm_o(n_imm), .alu_op_o(n_op),
      .reg_write_en_o(n_rwe), .mem_read_o(n_mrd),
      .mem_write_o(n_mwr), .mem_unsigned_o(n_mus),
      .branch_o(n_br), .jump_o(n_jmp), .jalr_o(n_jalr),
      .uses_rs1_o(n_u1), .uses_rs2_o(n_u2),
      .is_muldiv_o(n_md), .mem_size_o(n_msz),
      .result_src_o(n_rsrc), .illegal_o(n_ill)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic b_t dut_b();
      b_t b;
      b.pc = d_pc; b.rs1 = d_rs1; b.rs2 = d_rs2; b.rd = d_rd;
      b.imm = d_imm; b.op = d_op; b.rwe = d_rwe; b.mrd = d_mrd;
      b.mwr = d_mwr; b.mus = d_mus; b.br = d_br; b.jmp = d_jmp;
      b.jalr = d_jalr; b.u1 = d_u1; b.u2 = d_u2; b.md = d_md;
      b.msz = d_msz; b.rsrc = d_rsrc; b.ill = d_ill;
      return b;
   endfunction

   function automatic b_t nom_b();
      b_t b;
      b.pc = n_pc; b.rs1 = n_rs1; b.rs2 = n_rs2; b.rd = n_rd;
      b.imm = n_imm; b.op = n_op; b.rwe = n_rwe; b.mrd = n_mrd;
      b.mwr = n_mwr; b.mus = n_mus; b.br = n_br; b.jmp = n_jmp;
      b.jalr = n_jalr; b.u1 = n_u1; b.u2 = n_u2; b.md = n_md;
      b.msz = n_msz; b.rsrc = n_rsrc; b.ill = n_ill;
      return b;
   endfunction

   // reference decode straight from the ISA encoding rules
   function automatic b_t model(input logic [31:0] i,
                                input logic [31:0] p, input bit men);
      b_t e;
      logic [2:0] f3;
      logic [6:0] f7;
      bit wr;
      int op;
      logic [31:0] ii, is, ib, iu, ij;
      e = '0; f3 = i[14:12]; f7 = i[31:25]; wr = 0; op = 0;
      e.pc = p; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
      ii = 32'($signed(i[31:20]));
      is = 32'($signed({i[31:25], i[11:7]}));
      ib = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      iu = {i[31:12], 12'h000};
      ij = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      case (i[6:0])
         7'h37: begin wr = 1; e.imm = iu; e.rsrc = 2'b11; end
         7'h17: begin wr = 1; e.imm = iu; end
         7'h6F: begin wr = 1; e.jmp = 1; e.rsrc = 2'b10; e.imm = ij; end
         7'h67: begin
            wr = 1; e.jmp = 1; e.jalr = 1; e.u1 = 1;
            e.rsrc = 2'b10; e.imm = ii; e.ill = (f3 != 0);
         end
         7'h63: begin
            e.br = 1; e.u1 = 1; e.u2 = 1; e.imm = ib;
            if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1;
            else op = (f3 < 3'd2) ? 10 + int'(f3) : 8 + int'(f3);
         end
         7'h03: begin
            wr = 1; e.mrd = 1; e.u1 = 1; e.rsrc = 2'b01; e.imm = ii;
            e.msz = f3[1:0]; e.mus = f3[2];
            e.ill = (f3 == 3'd3 || f3 >= 3'd6);
         end
         7'h23: begin
            e.mwr = 1; e.u1 = 1; e.u2 = 1; e.imm = is;
            e.msz = f3[1:0]; e.ill = (f3 >= 3'd3);
         end
         7'h13: begin
            wr = 1; e.u1 = 1; e.imm = ii; op = ALU_T[f3];
            if (f3 == 3'd1) begin
               e.imm = 32'(i[24:20]); e.ill = (f7 != 0);
            end
            if (f3 == 3'd5) begin
               e.imm = 32'(i[24:20]);
               if (f7 == 7'h20) op = 7;
               else if (f7 != 0) e.ill = 1;
            end
         end
         7'h33: begin
            wr = 1; e.u1 = 1; e.u2 = 1;
            if (f7 == 7'h01) begin
               if (men) begin op = 16 + int'(f3); e.md = 1; end
               else e.ill = 1;
            end else if (f7 == 0) op = ALU_T[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
            else e.ill = 1;
         end
         default: e.ill = 1;
      endcase
      e.op = 5'(op);
      e.rwe = wr && !e.ill && (e.rd != 0);
      if (e.ill) begin
         e.mrd = 0; e.mwr = 0; e.br = 0; e.jmp = 0;
      end
      return e;
   endfunction

   function automatic b_t keep(input b_t b);
      b_t k;
      k = b;
      k.imm = '0; k.op = '0; k.mus = 0; k.jalr = 0; k.u1 = 0;
      k.u2 = 0; k.md = 0; k.msz = '0; k.rsrc = '0;
      return k;
   endfunction

   task automatic cmp_payload(input string tag, input b_t o,
                              input b_t e);
      b_t oo, ee;
      oo = o; ee = e;
      if (e.ill) begin
         oo = keep(o); ee = keep(e);
      end
      chk(tag, oo, ee);
   endtask

   function automatic logic [31:0] addi(input int k);
      return {12'(k), 5'd0, 3'b000, 5'(k), 7'h13};
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 10))
         0, 1: begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 3))
               0: w[31:25] = 7'h00;
               1: w[31:25] = 7'h20;
               2: w[31:25] = 7'h01;
               default: ;
            endcase
         end
         2, 3: begin
            w[6:0] = 7'h13;
            case ($urandom_range(0, 2))
               0: w[31:25] = 7'h00;
               1: w[31:25] = 7'h20;
               default: ;
            endcase
         end
         4: w[6:0] = 7'h03;
         5: w[6:0] = 7'h23;
         6: w[6:0] = 7'h63;
         7: w[6:0] = 7'h6F;
         8: begin
            w[6:0] = 7'h67;
            if ($urandom_range(0, 3) != 0) w[14:12] = 3'b000;
         end
         9: w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
         default: ;
      endcase
      return w;
   endfunction

   task automatic send(input logic [31:0] ins, input logic [31:0] p);
      in_valid = 1'b1; instr = ins; pc = p; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   tx_t  q[$];
   logic [4:0] got[$];
   bit   acc, fire, seen;
   int   nxt;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; instr = '0; pc = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_payload", dut_b(), '0);
      chk("rst_hs", {in_ready, out_valid}, 2'b10);

      send(32'h002081B3, 32'h0000_1000);
      chk("add", {out_valid, d_op, d_rd, d_rs1, d_rs2, d_rwe,
                  d_u1, d_u2, d_ill},
          {1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0});
      chk("add_pc", d_pc, 32'h0000_1000);

      send(32'h027302B3, 32'h0000_1004);
      chk("mul_m", {d_op, d_md, d_ill, d_rwe},
          {5'd16, 1'b1, 1'b0, 1'b1});
      chk("mul_nom", {n_ill, n_rwe, n_md}, {1'b1, 1'b0, 1'b0});

      send(32'hFFFF_FFFF, 32'h0000_1008);
      chk("ill_ones", {d_ill, d_rwe, d_mrd, d_mwr, d_br, d_jmp},
          {1'b1, 5'b0});
      send(32'h0000_2063, 32'h0000_100C);
      chk("ill_br", {d_ill, d_br}, {1'b1, 1'b0});
      send(32'h0000_0013, 32'h0000_1010);
      chk("addi_x0", {d_ill, d_rwe}, {1'b0, 1'b0});
      send(32'h4010_D093, 32'h0000_1014);
      chk("srai", {d_op, d_imm, d_ill}, {5'd7, 32'd1, 1'b0});
      send(32'h8000_00EF, 32'h0000_1018);
      chk("jal", {d_jmp, d_rsrc, d_imm, d_rwe, d_rd},
          {1'b1, 2'b10, 32'hFFF0_0000, 1'b1, 5'd1});

      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("drain", out_valid, 1'b0);

      out_ready = 1'b0;
      in_valid = 1'b1; instr = addi(1); pc = 32'h100;
      @(posedge clk); #1;
      instr = addi(2); pc = 32'h104;
      @(posedge clk); #1;
      chk("bp_ready", in_ready, 1'b0);
      instr = addi(3); pc = 32'h108;
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, d_rd, d_imm, d_pc},
          {1'b1, 1'b0, 5'd1, 32'd1, 32'h100});
      out_ready = 1'b1; nxt = 3; got.delete();
      for (int c = 0; c < 20 && got.size() < 4; c++) begin
         in_valid = (nxt <= 4);
         instr = addi(nxt); pc = 32'h100 + 32'(4 * (nxt - 1));
         if (out_valid && out_ready) got.push_back(d_rd);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) nxt++;
      end
      in_valid = 1'b0;
      chk("bp_count", got.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < got.size()) chk("bp_order", got[k], 5'(k + 1));
      chk("bp_empty", out_valid, 1'b0);

      out_ready = 1'b0; in_valid = 1'b1; instr = addi(5);
      @(posedge clk); #1;
      instr = addi(6);
      @(posedge clk); #1;
      chk("fl_two", {out_valid, in_ready}, 2'b10);
      flush = 1'b1; instr = addi(7);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_empty", {out_valid, in_ready}, 2'b01);
      out_ready = 1'b1; seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (out_valid) seen = 1;
         @(posedge clk); #1;
      end
      chk("fl_drop", seen, 1'b0);

      out_ready = 1'b0; in_valid = 1'b1; instr = addi(8);
      @(posedge clk); #1;
      flush = 1'b1; instr = addi(9);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_one", out_valid, 1'b0);
      @(posedge clk); #1;
      chk("fl_one_drop", out_valid, 1'b0);

      q.delete();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         chk("rnd_ready", in_ready, q.size() < 2);
         chk("rnd_valid", out_valid, q.size() > 0);
         if (q.size() > 0) begin
            cmp_payload("rnd_m", dut_b(),
                        model(q[0].ins, q[0].pc, 1'b1));
            cmp_payload("rnd_nom", nom_b(),
                        model(q[0].ins, q[0].pc, 1'b0));
         end
         flush     = ($urandom_range(0, 39) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         instr     = gen_instr();
         pc        = $urandom;
         acc  = in_valid && (q.size() < 2) && !flush;
         fire = (q.size() > 0) && out_ready && !flush;
         @(posedge clk); #1;
         if (flush) q.delete();
         else begin
            if (fire) void'(q.pop_front());
            if (acc) q.push_back('{ins: instr, pc: pc});
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Registered, parametrised RV32I/RV32M decode stage placed between fetch and issue. It replaces the purely combinational decoder with the following additions:
- valid/ready handshake
- 2-entry skid buffer
- illegal-instruction detection
- optional M-extension decoding
- flush support
Decode logic is combinational on the input. Results are registered, giving one cycle of latency at full throughput.

Parameters:
DATA_WIDTH, 32, width of the instruction, PC and immediate.
ENABLE_M, 1, when 1 decode MUL/DIV/REM (funct7=0000001); when 0 these encodings are illegal.
ALU_OP_W, 5, width of alu_op_o; must be >=5.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous pipeline flush
in_valid_i  in  1  fetch offers instruction
in_ready_o  out  1  stage can accept
instr_i  in  DATA_WIDTH  raw instruction
pc_i  in  DATA_WIDTH  instruction PC
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  issue accepts bundle
pc_o  out  DATA_WIDTH  PC of the bundle
rs1_addr_o/rs2_addr_o/rd_addr_o  out  5 each  register fields
imm_o  out  DATA_WIDTH  sign-extended I/S/B/U/J immediate; 0 for R-type
alu_op_o  out  ALU_OP_W  operation code
reg_write_en_o, mem_read_o, mem_write_o, mem_unsigned_o, branch_o, jump_o, jalr_o, uses_rs1_o, uses_rs2_o, is_muldiv_o  out  1 each  control flags
mem_size_o  out  2  00 byte, 01 half, 10 word
result_src_o  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI)
illegal_o  out  1  illegal encoding

Behaviour:
- Reset: all outputs are 0, in_ready_o is 1 after reset release, and both buffer entries are invalid.
- Handshake:
  - accept = in_valid_i & in_ready_o.
  - fire = out_valid_o & out_ready_i.
  - When out_valid_o=1 and out_ready_i=0, every payload output holds stable.
- Buffer FSM, with in_ready_o = (state != TWO) and out_valid_o = (state != EMPTY):
  - EMPTY: accept -> ONE, main entry loaded.
  - ONE, accept & fire: stays ONE, main reloaded.
  - ONE, accept & !fire: -> TWO, new bundle goes to the skid entry.
  - ONE, fire only: -> EMPTY.
  - TWO: fire -> ONE, skid moves to main. No accept is possible.
- Flush: flush_i=1 forces EMPTY on the next edge and overrides accept in the same cycle (the input is dropped). No output fire is reported.
- Latency: a bundle accepted in cycle N presents at out_valid_o in cycle N+1, provided the buffer was EMPTY or fired in cycle N.
- alu_op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Loads, stores, AUIPC, JAL, JALR and LUI use 0.
- is_muldiv_o=1 only for codes 16-23.
- Loads:
  - LB/LH/LW sign-extend; LBU/LHU set mem_unsigned_o=1.
  - Load funct3 011/110/111 is illegal.
  - Store funct3 >=011 is illegal.
- Illegal when any of the following holds:
  - unknown opcode
  - branch funct3 010/011
  - JALR funct3 != 000
  - R-type funct7 not in {0000000, 0100000 (funct3 000/101 only), 0000001 (ENABLE_M=1)}
  - SLLI funct7 != 0
  - SRLI/SRAI funct7 not in {0000000, 0100000}
  - instr[1:0] != 11
- When illegal_o=1: reg_write_en_o, mem_read_o, mem_write_o, branch_o and jump_o are all 0. The bundle still flows through the handshake.
- rd=x0: reg_write_en_o is forced to 0 (including JAL/JALR). The jump still executes.
- Immediates:
  - I, S, B and J immediates are sign-extended from instr[31].
  - U = {instr[31:12], 12'b0}.
  - Shift-immediate imm_o carries instr[24:20] zero-extended.

Test Plan:
- Reset, then instr 0x002081B3 (ADD x3,x1,x2) with out_ready=1 -> next cycle: out_valid=1, alu_op=0, rd=3, rs1=1, rs2=2, reg_write_en=1, uses_rs1=uses_rs2=1, illegal=0.
- 0x027302B3 (MUL x5,x6,x7): ENABLE_M=1 -> alu_op=16, is_muldiv=1. ENABLE_M=0 -> illegal=1, reg_write_en=0.
- Illegal-encoding sweep: 0xFFFFFFFF -> illegal=1. 0x00002063 (branch funct3 010) -> illegal=1, branch=0. 0x00000013 (ADDI x0) -> illegal=0, reg_write_en=0.
- 0x4010D093 (SRAI x1,x1,1) -> alu_op=7, imm=1. 0x800000EF (JAL x1,-1MiB) -> jump=1, result_src=10, imm=0xFFF00000.
- Backpressure: stream 4 back-to-back ADDIs with out_ready held 0 -> in_ready drops after 2 accepts and outputs hold the first bundle. Release out_ready -> all 4 bundles emerge in order with no loss or duplicate.
- Flush in TWO state, with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.
